// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate lane.
// Holds the default widths, a wide signed working type, and the
// sign-extension and saturating-add helpers used by mac_acc_unit.
package mac_pkg;

  localparam int DW_D = 8;   // activation / weight width
  localparam int CW_D = 16;  // bias width
  localparam int AW_D = 20;  // accumulator / result width

  // Helpers work at a fixed wide width. Callers hand in zero-extended
  // operands, and the helpers interpret them at the narrower width given.
  localparam int unsigned MAXW = 64;
  typedef logic signed [MAXW-1:0] wide_t;

  // Sign-extends the low w bits of v to the full working width.
  function automatic wide_t sext(input wide_t v, input int unsigned w);
    int unsigned sh;
    sh = MAXW - w;
    return (v <<< sh) >>> sh;
  endfunction

  // Adds two values that are already in the aw-bit signed range. Returns
  // {ovf, result}. The result is clamped when sat is set, and otherwise
  // wraps modulo 2^aw. The result comes back sign-extended, so callers can
  // take its low aw bits. The sum of two aw-bit operands fits easily in
  // MAXW bits, so this gives the same outcome as an aw+1-bit adder.
  function automatic logic [MAXW:0] sat_add(input wide_t a, input wide_t b,
                                            input int unsigned aw, input logic sat);
    wide_t sum;
    wide_t hi;
    wide_t lo;
    wide_t res;
    logic  ovf;
    hi  = (wide_t'(1) <<< (aw - 1)) - wide_t'(1);
    lo  = ~hi;
    sum = a + b;
    ovf = (sum > hi) || (sum < lo);
    if (!ovf)     res = sum;
    else if (sat) res = sum[MAXW-1] ? lo : hi;
    else          res = sext(sum, aw);
    return {ovf, res};
  endfunction

endpackage

// File: rtl/mac_mul_stage.sv
// Stage 1 of the MAC lane: the weight register, the signed multiplier and
// the stage-1 pipeline registers. The multiplier lives in its own module
// so that it can be swapped for a hard-macro multiplier later.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   w_load, wi       weight load strobe and value
//   x_valid, xi      activation term and its qualifier
//   x_first, x_last  sequence delimiters for the term
//   ci               bias, captured with the first term
//   v1, f1, l1       stage-1 valid / first / last flags
//   p_r              registered full-width signed product
//   ci_r             registered bias
module mac_mul_stage
  import mac_pkg::*;
#(
  parameter int DW = DW_D,
  parameter int CW = CW_D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            w_load,
  input  logic [DW-1:0]   wi,
  input  logic            x_valid,
  input  logic [DW-1:0]   xi,
  input  logic            x_first,
  input  logic            x_last,
  input  logic [CW-1:0]   ci,
  output logic            v1,
  output logic            f1,
  output logic            l1,
  output logic [2*DW-1:0] p_r,
  output logic [CW-1:0]   ci_r
);

  logic [DW-1:0]          w_r;
  logic signed [2*DW-1:0] prod;

  // Both operands are extended to 2*DW bits as signed values, so the
  // corner case -2^(DW-1) squared still fits.
  always_comb prod = $signed(xi) * $signed(w_r);

  // The product uses the old weight when a load happens on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_r <= '0;
    end else if (w_load) begin
      w_r <= wi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      f1   <= 1'b0;
      l1   <= 1'b0;
      p_r  <= '0;
      ci_r <= '0;
    end else begin
      v1 <= x_valid;
      if (x_valid) begin
        p_r <= prod;
        f1  <= x_first;
        l1  <= x_last;
        if (x_first) ci_r <= ci;
      end
    end
  end

endmodule

// File: rtl/mac_acc_unit.sv
// Signed multiply-accumulate lane. It multiplies a stream of activations by
// a loaded weight and accumulates each first..last sequence on top of a
// bias. It emits one result per sequence, with optional saturation and a
// sticky per-sequence overflow flag.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   w_load, wi        weight load strobe and value
//   x_valid, xi       activation term and its qualifier
//   x_first, x_last   sequence delimiters
//   ci                bias, sampled with x_valid & x_first
//   co_valid          one-cycle pulse marking co/ovf valid
//   co                accumulated result
//   ovf               an overflow occurred somewhere in the sequence
module mac_acc_unit
  import mac_pkg::*;
#(
  parameter int DW  = DW_D,
  parameter int CW  = CW_D,
  parameter int AW  = AW_D,
  parameter int SAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_load,
  input  logic [DW-1:0] wi,
  input  logic          x_valid,
  input  logic [DW-1:0] xi,
  input  logic          x_first,
  input  logic          x_last,
  input  logic [CW-1:0] ci,
  output logic          co_valid,
  output logic [AW-1:0] co,
  output logic          ovf
);

  logic            v1;
  logic            f1;
  logic            l1;
  logic [2*DW-1:0] p_r;
  logic [CW-1:0]   ci_r;

  logic [AW-1:0]   acc;
  logic            ovf_acc;
  logic [AW-1:0]   acc_nxt;
  logic            ovf_nxt;
  wide_t           base;
  wide_t           prod_w;
  logic [MAXW:0]   sa;
  logic            unused_hi;

  mac_mul_stage #(
    .DW(DW),
    .CW(CW)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .w_load (w_load),
    .wi     (wi),
    .x_valid(x_valid),
    .xi     (xi),
    .x_first(x_first),
    .x_last (x_last),
    .ci     (ci),
    .v1     (v1),
    .f1     (f1),
    .l1     (l1),
    .p_r    (p_r),
    .ci_r   (ci_r)
  );

  // A first term restarts the sequence from the bias, and it also clears
  // the sticky overflow.
  always_comb begin
    base    = f1 ? sext(wide_t'(ci_r), CW) : sext(wide_t'(acc), AW);
    prod_w  = sext(wide_t'(p_r), 2 * DW);
    sa      = sat_add(base, prod_w, AW, SAT != 0);
    acc_nxt = sa[AW-1:0];
    ovf_nxt = (f1 ? 1'b0 : ovf_acc) | sa[MAXW];
  end

  // The upper bits only repeat the sign of the result.
  assign unused_hi = ^sa[MAXW-1:AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      ovf_acc  <= 1'b0;
      co       <= '0;
      ovf      <= 1'b0;
      co_valid <= 1'b0;
    end else begin
      co_valid <= 1'b0;
      if (v1) begin
        acc     <= acc_nxt;
        ovf_acc <= ovf_nxt;
        if (l1) begin
          co       <= acc_nxt;
          ovf      <= ovf_nxt;
          co_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_unit.sv
module tb_mac_acc_unit;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int AW = 20;
  localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (AW - 1));

  typedef logic signed [63:0] lw_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          w_load;
  logic [DW-1:0] wi;
  logic          x_valid;
  logic [DW-1:0] xi;
  logic          x_first;
  logic          x_last;
  logic [CW-1:0] ci;
  logic          co_valid_s, co_valid_w;
  logic [AW-1:0] co_s, co_w;
  logic          ovf_s, ovf_w;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: one lane per saturation mode.
  longint w_m;
  longint acc_s, acc_w;
  bit     ovf_ms, ovf_mw;
  bit     pend_v;
  longint pend_s, pend_w;
  bit     pend_os, pend_ow;
  longint hold_s, hold_w;
  bit     hold_os, hold_ow;

  always #5 clk = ~clk;

  mac_acc_unit #(.DW(DW), .CW(CW), .AW(AW), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .wi(wi), .x_valid(x_valid),
    .xi(xi), .x_first(x_first), .x_last(x_last), .ci(ci),
    .co_valid(co_valid_s), .co(co_s), .ovf(ovf_s)
  );

  mac_acc_unit #(.DW(DW), .CW(CW), .AW(AW), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .wi(wi), .x_valid(x_valid),
    .xi(xi), .x_first(x_first), .x_last(x_last), .ci(ci),
    .co_valid(co_valid_w), .co(co_w), .ovf(ovf_w)
  );

  task automatic check(input string tag, input lw_t obs, input lw_t exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap(input longint s);
    longint m, r;
    m = longint'(1) << AW;
    r = (s - MINV) % m;
    if (r < 0) r += m;
    return r + MINV;
  endfunction

  task automatic model_clear();
    w_m = 0; acc_s = 0; acc_w = 0; ovf_ms = 0; ovf_mw = 0;
    pend_v = 0; pend_s = 0; pend_w = 0; pend_os = 0; pend_ow = 0;
    hold_s = 0; hold_w = 0; hold_os = 0; hold_ow = 0;
  endtask

  // Applies one term to the reference model with plain integer arithmetic.
  task automatic model_term(input int x, input bit f, input int c);
    longint s;
    bit o;
    s = (f ? longint'(c) : acc_s) + longint'(x) * w_m;
    o = (s > MAXV) || (s < MINV);
    ovf_ms = (f ? 1'b0 : ovf_ms) | o;
    acc_s = (s > MAXV) ? MAXV : (s < MINV) ? MINV : s;
    s = (f ? longint'(c) : acc_w) + longint'(x) * w_m;
    o = (s > MAXV) || (s < MINV);
    ovf_mw = (f ? 1'b0 : ovf_mw) | o;
    acc_w = wrap(s);
  endtask

  // Drives one cycle, then checks all outputs of both lanes after the edge.
  task automatic step(input bit wl, input int wv, input bit xv, input int x,
                      input bit f, input bit l, input int c);
    w_load = wl; wi = DW'(wv); x_valid = xv; xi = DW'(x);
    x_first = f; x_last = l; ci = CW'(c);
    @(posedge clk); #1;
    if (pend_v) begin
      hold_s = pend_s; hold_w = pend_w; hold_os = pend_os; hold_ow = pend_ow;
    end
    check("co_valid_sat",  lw_t'(co_valid_s), lw_t'(pend_v));
    check("co_valid_wrap", lw_t'(co_valid_w), lw_t'(pend_v));
    check("co_sat",  lw_t'($signed(co_s)), lw_t'(hold_s));
    check("co_wrap", lw_t'($signed(co_w)), lw_t'(hold_w));
    check("ovf_sat",  lw_t'(ovf_s), lw_t'(hold_os));
    check("ovf_wrap", lw_t'(ovf_w), lw_t'(hold_ow));
    pend_v = 0;
    if (xv) begin
      model_term(x, f, c);
      if (l) begin
        pend_v = 1; pend_s = acc_s; pend_w = acc_w; pend_os = ovf_ms; pend_ow = ovf_mw;
      end
    end
    if (wl) w_m = longint'(wv);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Checks both lanes directly against constants taken from the test plan.
  task automatic expect_co(input string tag, input longint vs, input longint vw, input bit o);
    check({tag, "_valid_s"}, lw_t'(co_valid_s), lw_t'(1));
    check({tag, "_valid_w"}, lw_t'(co_valid_w), lw_t'(1));
    check({tag, "_co_s"}, lw_t'($signed(co_s)), lw_t'(vs));
    check({tag, "_co_w"}, lw_t'($signed(co_w)), lw_t'(vw));
    check({tag, "_ovf_s"}, lw_t'(ovf_s), lw_t'(o));
    check({tag, "_ovf_w"}, lw_t'(ovf_w), lw_t'(o));
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    w_load = 0; x_valid = 0; x_first = 0; x_last = 0;
    #1;
    model_clear();
    check("rst_valid_s", lw_t'(co_valid_s), lw_t'(0));
    check("rst_valid_w", lw_t'(co_valid_w), lw_t'(0));
    check("rst_co_s", lw_t'($signed(co_s)), lw_t'(0));
    check("rst_co_w", lw_t'($signed(co_w)), lw_t'(0));
    check("rst_ovf_s", lw_t'(ovf_s), lw_t'(0));
    idle();
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; w_load = 0; wi = '0; x_valid = 0; xi = '0;
    x_first = 0; x_last = 0; ci = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", lw_t'(co_valid_s), lw_t'(0));
    check("reset_co", lw_t'($signed(co_s)), lw_t'(0));
    check("reset_ovf", lw_t'(ovf_w), lw_t'(0));
    rst_n = 1'b1;

    // 1. basic sequence
    step(1, 3, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0, 10);
    step(0, 0, 1, 2, 0, 0, 0);
    step(0, 0, 1, 3, 0, 1, 0);
    idle();
    expect_co("basic", 28, 28, 0);
    idle();

    // 2. signed corners, back to back
    step(1, -128, 0, 0, 0, 0, 0);
    step(0, 0, 1, -128, 1, 1, 0);
    step(0, 0, 1, 127, 1, 1, -5);
    expect_co("corner_sq", 16384, 16384, 0);
    idle();
    expect_co("corner_neg", -16261, -16261, 0);

    // 3. overflow, then recovery and post-clamp accumulation
    for (int i = 0; i < 32; i++) step(0, 0, 1, -128, i == 0, i == 31, 0);
    idle();
    expect_co("ovf", 524287, -524288, 1);
    step(0, 0, 1, 1, 1, 1, 0);
    idle();
    expect_co("ovf_clear", -128, -128, 0);
    for (int i = 0; i < 33; i++) step(0, 0, 1, (i == 32) ? 127 : -128, i == 0, i == 32, 0);
    idle();
    idle();

    // 4. weight load timing
    step(1, 3, 0, 0, 0, 0, 0);
    step(1, 5, 1, 2, 1, 1, 0);
    step(0, 0, 1, 2, 1, 1, 0);
    expect_co("wload_old", 6, 6, 0);
    idle();
    expect_co("wload_new", 10, 10, 0);

    // 5. bubbles and back-to-back sequences
    step(1, 2, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0);
    idle();
    step(0, 0, 1, 1, 0, 0, 0);
    idle();
    step(0, 0, 1, 1, 0, 1, 0);
    step(0, 0, 1, 4, 1, 1, 1);
    expect_co("bubble_seq", 6, 6, 0);
    idle();
    expect_co("b2b_seq", 9, 9, 0);
    idle();

    // 6. reset mid-sequence
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 1, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0);
    do_reset();
    idle();
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 7, 1, 1, 0);
    idle();
    expect_co("after_reset", 7, 7, 0);

    // Randomized traffic against the model, including open-sequence accumulation.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(7) == 0, int'($urandom_range(255)) - 128,
           $urandom_range(3) != 0, int'($urandom_range(255)) - 128,
           $urandom_range(3) == 0, $urandom_range(3) == 0,
           int'($urandom_range(65535)) - 32768);
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
